// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and helpers for the N-way set-associative data cache.
//   - state_t      : miss-handling FSM states
//   - calc_*       : derived field widths, usable in localparam declarations
//   - addr_*       : address field extraction (offset / index / tag / word)
// Address helpers operate on a zero-extended 64-bit address so a single set
// of functions serves any ADDR_W up to 64; callers cast the result down.
// -----------------------------------------------------------------------------
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    localparam int ADDR_MAX_W = 64;

    function automatic int calc_offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int calc_index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int line_w, input int sets);
        return addr_w - calc_offset_w(line_w) - calc_index_w(sets);
    endfunction

    function automatic int calc_age_w(input int ways);
        return $clog2(ways);
    endfunction

    function automatic int calc_words_per_line(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    // Set index: the bits just above the line offset.
    function automatic logic [ADDR_MAX_W-1:0] addr_index(
        input logic [ADDR_MAX_W-1:0] addr,
        input int                    line_w,
        input int                    sets
    );
        logic [ADDR_MAX_W-1:0] mask;
        mask = (ADDR_MAX_W'(1) << calc_index_w(sets)) - ADDR_MAX_W'(1);
        return (addr >> calc_offset_w(line_w)) & mask;
    endfunction

    // Tag: everything above offset and index.
    function automatic logic [ADDR_MAX_W-1:0] addr_tag(
        input logic [ADDR_MAX_W-1:0] addr,
        input int                    line_w,
        input int                    sets
    );
        return addr >> (calc_offset_w(line_w) + calc_index_w(sets));
    endfunction

    // Word select inside the line: offset bits above the byte-in-word bits.
    function automatic logic [ADDR_MAX_W-1:0] addr_word(
        input logic [ADDR_MAX_W-1:0] addr,
        input int                    line_w,
        input int                    word_w
    );
        logic [ADDR_MAX_W-1:0] mask;
        mask = ADDR_MAX_W'(calc_words_per_line(line_w, word_w) - 1);
        return (addr >> $clog2(word_w / 8)) & mask;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// -----------------------------------------------------------------------------
// dcache_lru
// Combinational age-based LRU for one cache set.
// Ports:
//   age_i      : current age per way (0 = most recently used)
//   access_i   : way being accessed this cycle
//   invalid_i  : per-way invalid mask
//   age_o      : ages after an access to access_i
//   victim_o   : replacement candidate (lowest invalid way, else oldest way)
// Ages always form a permutation of 0..WAYS-1, so exactly one way holds the
// age WAYS-1 whenever the set is full.
// -----------------------------------------------------------------------------
module dcache_lru
    import dcache_pkg::*;
#(
    parameter  int WAYS  = 2,
    localparam int AGE_W = calc_age_w(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] age_i,
    input  logic [AGE_W-1:0]           access_i,
    input  logic [WAYS-1:0]            invalid_i,
    output logic [WAYS-1:0][AGE_W-1:0] age_o,
    output logic [AGE_W-1:0]           victim_o
);

    logic [AGE_W-1:0] access_age;
    assign access_age = age_i[access_i];

    // Ways younger than the accessed one age by one; the accessed way becomes
    // the youngest. Older ways keep their age.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_age
            assign age_o[gi] = (AGE_W'(gi) == access_i)  ? '0 :
                               (age_i[gi] < access_age)   ? age_i[gi] + AGE_W'(1) :
                                                            age_i[gi];
        end
    endgenerate

    always_comb begin
        logic found;
        found    = 1'b0;
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && invalid_i[w]) begin
                victim_o = AGE_W'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_i[w] == AGE_W'(WAYS - 1)) begin
                    victim_o = AGE_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// -----------------------------------------------------------------------------
// dcache_nway
// N-way set-associative, write-back, write-allocate data cache for the MEM
// stage. Hits complete combinationally; misses stall the core while the
// victim is written back (if dirty) and the line is refilled.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   p1_addr_i / p1_data_i        : CPU word address and store data
//   p1_MemRead_i / p1_MemWrite_i : load / store request (both = store)
//   p1_data_o                    : load data (0 unless a load hits)
//   p1_stall_o                   : request not yet complete
//   mem_*                        : line-wide memory port, registered request,
//                                  one-cycle mem_ack_i completion pulse
// Tag/data arrays are read combinationally because a hit must finish in the
// same cycle it is presented.
// -----------------------------------------------------------------------------
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int WAYS   = 2,
    parameter int LINE_W = 256,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFFSET_W       = calc_offset_w(LINE_W);
    localparam int INDEX_W        = calc_index_w(SETS);
    localparam int TAG_W          = calc_tag_w(ADDR_W, LINE_W, SETS);
    localparam int AGE_W          = calc_age_w(WAYS);
    localparam int WAY_W          = AGE_W;
    localparam int WORDS_PER_LINE = calc_words_per_line(LINE_W, WORD_W);
    localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

    // ---------------------------------------------------------------- storage
    logic [WAYS-1:0]            valid_reg [SETS];
    logic [WAYS-1:0]            dirty_reg [SETS];
    logic [WAYS-1:0][AGE_W-1:0] age_reg   [SETS];
    logic [TAG_W-1:0]           tag_reg   [SETS][WAYS];
    logic [LINE_W-1:0]          data_reg  [SETS][WAYS];

    state_t             state_reg, state_next;
    logic [WAY_W-1:0]   victim_reg;
    logic [INDEX_W-1:0] miss_index_reg;
    logic [TAG_W-1:0]   miss_tag_reg;
    logic               mem_enable_reg;
    logic               mem_write_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [LINE_W-1:0]  mem_data_reg;

    // ---------------------------------------------------------------- decode
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  req_word;

    assign req_index = INDEX_W'(addr_index(ADDR_MAX_W'(p1_addr_i), LINE_W, SETS));
    assign req_tag   = TAG_W'(addr_tag(ADDR_MAX_W'(p1_addr_i), LINE_W, SETS));
    assign req_word  = WSEL_W'(addr_word(ADDR_MAX_W'(p1_addr_i), LINE_W, WORD_W));

    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index
    );
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

    // ---------------------------------------------------------------- lookup
    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way;
    logic             hit;
    logic [LINE_W-1:0] hit_line;
    logic [WORD_W-1:0] hit_word;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_tag_cmp
            assign hit_vec[gi] = valid_reg[req_index][gi] &&
                                 (tag_reg[req_index][gi] == req_tag);
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit      = |hit_vec;
    assign hit_line = data_reg[req_index][hit_way];
    assign hit_word = hit_line[req_word*WORD_W +: WORD_W];

    // ---------------------------------------------------------------- LRU
    logic [WAYS-1:0][AGE_W-1:0] age_next;
    logic [WAY_W-1:0]           victim_way;
    logic                       victim_valid;
    logic                       victim_dirty;

    dcache_lru #(.WAYS(WAYS)) u_lru (
        .age_i     (age_reg[req_index]),
        .access_i  (hit_way),
        .invalid_i (~valid_reg[req_index]),
        .age_o     (age_next),
        .victim_o  (victim_way)
    );

    assign victim_valid = valid_reg[req_index][victim_way];
    assign victim_dirty = dirty_reg[req_index][victim_way];

    // ---------------------------------------------------------------- control
    logic req, is_write, idle, hit_access, miss_start;

    // A simultaneous read and write is handled as a write.
    assign req        = p1_MemRead_i | p1_MemWrite_i;
    assign is_write   = p1_MemWrite_i;
    assign idle       = (state_reg == ST_IDLE);
    assign hit_access = idle && req && hit;
    assign miss_start = idle && req && !hit;

    assign p1_stall_o = !rst_i && req && (!idle || !hit);
    assign p1_data_o  = (!rst_i && hit_access && !is_write) ? hit_word : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (miss_start) begin
                    state_next = (victim_valid && victim_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) state_next = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                if (mem_ack_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM, miss context and registered memory request. After a write-back ack
    // the enable drops for one cycle before the refill request is raised.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            victim_reg     <= '0;
            miss_index_reg <= '0;
            miss_tag_reg   <= '0;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (miss_start) begin
                        victim_reg     <= victim_way;
                        miss_index_reg <= req_index;
                        miss_tag_reg   <= req_tag;
                        mem_enable_reg <= 1'b1;
                        if (victim_valid && victim_dirty) begin
                            mem_write_reg <= 1'b1;
                            mem_addr_reg  <= line_addr(tag_reg[req_index][victim_way], req_index);
                            mem_data_reg  <= data_reg[req_index][victim_way];
                        end else begin
                            mem_write_reg <= 1'b0;
                            mem_addr_reg  <= line_addr(req_tag, req_index);
                            mem_data_reg  <= '0;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_enable_reg <= 1'b0;
                        mem_write_reg  <= 1'b0;
                        mem_addr_reg   <= '0;
                        mem_data_reg   <= '0;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        mem_enable_reg <= 1'b0;
                        mem_write_reg  <= 1'b0;
                        mem_addr_reg   <= '0;
                        mem_data_reg   <= '0;
                    end else if (!mem_enable_reg) begin
                        mem_enable_reg <= 1'b1;
                        mem_write_reg  <= 1'b0;
                        mem_addr_reg   <= line_addr(miss_tag_reg, miss_index_reg);
                        mem_data_reg   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status bits and ages: reset invalidates every line and restores the
    // age permutation way i -> i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_reg[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (hit_access) begin
                        age_reg[req_index] <= age_next;
                        if (is_write) dirty_reg[req_index][hit_way] <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) dirty_reg[miss_index_reg][victim_reg] <= 1'b0;
                end
                ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        valid_reg[miss_index_reg][victim_reg] <= 1'b1;
                        dirty_reg[miss_index_reg][victim_reg] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (hit_access && is_write) begin
                data_reg[req_index][hit_way][req_word*WORD_W +: WORD_W] <= p1_data_i;
            end
            if ((state_reg == ST_ALLOCATE) && mem_ack_i) begin
                data_reg[miss_index_reg][victim_reg] <= mem_data_i;
                tag_reg[miss_index_reg][victim_reg]  <= miss_tag_reg;
            end
        end
    end

    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;

endmodule

// File: tb/tb_dcache_nway.sv
// -----------------------------------------------------------------------------
// tb_dcache_nway
// Scoreboard bench for dcache_nway (SETS=16, WAYS=2). Stimulus pushes the
// expected CPU responses and memory requests into queues; monitors pop and
// compare when the DUT completes a request or raises mem_enable_o.
// Memory model: ack 10 cycles after enable rises; unwritten lines hold
// 0xC0DE0000 | byte_address[15:0] in every word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dcache_nway;

    localparam int ACK_DELAY = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         rd;
    logic         wr;
    logic [31:0]  rdata;
    logic         stall;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_addr;
    logic         mem_en;
    logic         mem_wr;

    always #5 clk = ~clk;

    dcache_nway dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p1_addr_i     (addr),
        .p1_data_i     (wdata),
        .p1_MemRead_i  (rd),
        .p1_MemWrite_i (wr),
        .p1_data_o     (rdata),
        .p1_stall_o    (stall),
        .mem_data_i    (mem_rdata),
        .mem_ack_i     (mem_ack),
        .mem_data_o    (mem_wdata),
        .mem_addr_o    (mem_addr),
        .mem_enable_o  (mem_en),
        .mem_write_o   (mem_wr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endfunction

    function automatic logic [255:0] default_line(input logic [31:0] a);
        logic [255:0] l;
        logic [15:0]  w;
        for (int j = 0; j < 8; j++) begin
            w = a[15:0] + 16'(j * 4);
            l[j*32 +: 32] = 32'hC0DE0000 | {16'h0, w};
        end
        return l;
    endfunction

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
    } resp_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        bit           chk_data;
        logic [255:0] data;
    } memreq_t;

    resp_t   resp_q[$];
    memreq_t mreq_q[$];

    // ---------------------------------------------------------------- memory
    logic [255:0] store [logic [31:0]];
    int inj_req = 0;

    initial begin
        int cnt;
        int inj_seen;
        cnt       = 0;
        inj_seen  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (inj_req != inj_seen) begin
                inj_seen++;
                mem_rdata = default_line(32'hFFFF_FFE0);
                mem_ack   = 1'b1;
            end else if (mem_en && !rst) begin
                cnt++;
                if (cnt == ACK_DELAY + 1) begin
                    if (mem_wr) store[mem_addr] = mem_wdata;
                    else mem_rdata = store.exists(mem_addr) ? store[mem_addr] : default_line(mem_addr);
                    mem_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin
        int      stall_cnt;
        logic    prev_en;
        resp_t   e;
        memreq_t m;
        stall_cnt = 0;
        prev_en   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
            end else begin
                if (mem_en && !prev_en) begin
                    if (mreq_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mem_req: unexpected request addr=%h write=%0b, required none", mem_addr, mem_wr);
                    end else begin
                        m = mreq_q.pop_front();
                        $display("mem req   addr=%h write=%0b", mem_addr, mem_wr);
                        check("mem_write", 256'(mem_wr), 256'(m.wr));
                        check("mem_addr", 256'(mem_addr), 256'(m.addr));
                        if (m.chk_data) check("mem_data", mem_wdata, m.data);
                    end
                end
                if (rd || wr) begin
                    if (stall) begin
                        stall_cnt++;
                    end else if (resp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL cpu_resp: unexpected completion addr=%h, required none", addr);
                        stall_cnt = 0;
                    end else begin
                        e = resp_q.pop_front();
                        $display("cpu %s addr=%h stall=%0d data=%h", e.is_read ? "load " : "store", addr, stall_cnt, rdata);
                        check("cpu_addr", 256'(addr), 256'(e.addr));
                        check("stall_cycles", 256'(stall_cnt), 256'(e.stall));
                        if (e.is_read) check("load_data", 256'(rdata), 256'(e.data));
                        stall_cnt = 0;
                    end
                end
            end
            prev_en = mem_en;
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic expect_mem(input bit w, input logic [31:0] a, input bit chk, input logic [255:0] d);
        memreq_t m;
        m.wr = w; m.addr = a; m.chk_data = chk; m.data = d;
        mreq_q.push_back(m);
    endtask

    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input int exp_stall);
        resp_t e;
        int    n;
        e.is_read = r && !w; e.addr = a; e.data = exp_data; e.stall = exp_stall;
        resp_q.push_back(e);
        @(posedge clk); #1;
        rd = r; wr = w; addr = a; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 200);
        if (stall) begin
            n_checks++;
            $display("FAIL request_timeout: addr=%h still stalled after %0d cycles, required completion", a, n);
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        logic [255:0] line;
        int n;
        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h400; wdata = '0;

        // Reset: outputs cleared, no stall even with a request present.
        @(negedge clk);
        check("reset_stall", 256'(stall), 256'(0));
        check("reset_rdata", 256'(rdata), 256'(0));
        check("reset_mem_enable", 256'(mem_en), 256'(0));
        check("reset_mem_write", 256'(mem_wr), 256'(0));
        check("reset_mem_addr", 256'(mem_addr), 256'(0));
        check("reset_mem_data", mem_wdata, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0; rd = 1'b0;

        // Cold miss (1 IDLE + 11 refill cycles), then hit in the same line.
        expect_mem(1'b0, 32'h400, 1'b0, '0);
        access(1, 0, 32'h400, 0, 32'hC0DE0400, 12);
        access(1, 0, 32'h404, 0, 32'hC0DE0404, 0);

        // Write hit, read back.
        access(0, 1, 32'h408, 32'hDEADBEEF, 0, 0);
        access(1, 0, 32'h408, 0, 32'hDEADBEEF, 0);

        // Second way of set 0 fills without write-back; both lines then hit.
        expect_mem(1'b0, 32'h600, 1'b0, '0);
        access(1, 0, 32'h600, 0, 32'hC0DE0600, 12);
        access(1, 0, 32'h400, 0, 32'hC0DE0400, 0);
        access(1, 0, 32'h600, 0, 32'hC0DE0600, 0);

        // LRU eviction of dirty 0x400: 1 + 11 write-back + 1 gap + 11 refill.
        line = default_line(32'h400);
        line[95:64] = 32'hDEADBEEF;
        expect_mem(1'b1, 32'h400, 1'b1, line);
        expect_mem(1'b0, 32'h800, 1'b0, '0);
        access(1, 0, 32'h800, 0, 32'hC0DE0800, 24);

        // Read+write together acts as a store and dirties the line.
        access(1, 1, 32'h804, 32'h12345678, 0, 0);
        access(1, 0, 32'h804, 0, 32'h12345678, 0);
        access(1, 0, 32'h600, 0, 32'hC0DE0600, 0);
        line = default_line(32'h800);
        line[63:32] = 32'h12345678;
        expect_mem(1'b1, 32'h800, 1'b1, line);
        expect_mem(1'b0, 32'hA00, 1'b0, '0);
        access(1, 0, 32'hA00, 0, 32'hC0DE0A00, 24);

        // Reset five cycles into a refill of 0xC00.
        expect_mem(1'b0, 32'hC00, 1'b0, '0);
        @(posedge clk); #1;
        rd = 1'b1; addr = 32'hC00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_en && n < 50);
        if (!mem_en) begin
            n_checks++;
            $display("FAIL refill_start: mem_enable_o=0, required 1");
        end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_enable", 256'(mem_en), 256'(0));

        // Late ack in IDLE must be ignored.
        inj_req++;
        repeat (4) @(posedge clk);
        check("late_ack_no_request", 256'(mem_en), 256'(0));

        // All lines invalidated: 0x400 misses; memory now holds the written-back line.
        expect_mem(1'b0, 32'h400, 1'b0, '0);
        access(1, 0, 32'h400, 0, 32'hC0DE0400, 12);
        access(1, 0, 32'h408, 0, 32'hDEADBEEF, 0);

        repeat (5) @(posedge clk);
        check("resp_queue_drained", 256'(resp_q.size()), 256'(0));
        check("mem_queue_drained", 256'(mreq_q.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
